// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer with valid/ready on both sides
// Optional even-parity trailer bit enabled by defining SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SERIALIZER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             head;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             par;
`endif

  assign head    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign q_valid = (state == SHIFT);
  assign busy    = q_valid;
  assign q_last  = (state == SHIFT) && (cnt == CW'(N - 1));

  // Once all data bits have shifted out, the head position carries the stored parity.
`ifdef SERIALIZER_PARITY_EN
  assign q = q_valid & ((cnt == CW'(WIDTH)) ? par : head);
`else
  assign q = q_valid & head;
`endif

  assign din_ready = !rst && ((state == IDLE) || (q_last && q_ready));
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
      par   <= ^din;
`endif
    end else if ((state == SHIFT) && q_ready) begin
      if (q_last) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        if (MSB_FIRST) begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - table-driven scoreboard bench for piso_serializer (MSB- and LSB-first)
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  typedef struct {
    logic [7:0] w;
    logic [7:0] msb_seq;
    logic [7:0] lsb_seq;
    logic       par;
  } vec_t;

  typedef struct {
    logic d;
    logic last;
  } bit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       q_ready;
  logic       q0, qv0, ql0, b0, dr0;
  logic       q1, qv1, ql1, b1, dr1;

  vec_t tbl [8];
  bit_t sb0[$];
  bit_t sb1[$];
  int   cur_idx;
  int   errors = 0;
  int   checks = 0;
  int   valid_cycles, rises, dr_low;
  logic last_seen, prev_qv;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(dr0),
    .q(q0), .q_valid(qv0), .q_ready(q_ready), .q_last(ql0), .busy(b0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(dr1),
    .q(q1), .q_valid(qv1), .q_ready(q_ready), .q_last(ql1), .busy(b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int idx);
    bit_t e;
    for (int i = 0; i < 8; i++) begin
      e.last = (i == N - 1);
      e.d = tbl[idx].msb_seq[7-i];
      sb0.push_back(e);
      e.d = tbl[idx].lsb_seq[7-i];
      sb1.push_back(e);
    end
`ifdef SERIALIZER_PARITY_EN
    e.d = tbl[idx].par;
    e.last = 1'b1;
    sb0.push_back(e);
    sb1.push_back(e);
`endif
  endtask

  // Scoreboard: pop on each serial transfer, push a whole frame on each accept.
  always @(negedge clk) begin
    bit_t e;
    if (rst) begin
      sb0.delete();
      sb1.delete();
      prev_qv = 1'b0;
    end else begin
      if (qv0) valid_cycles++;
      if (qv0 && !prev_qv) rises++;
      if (!dr0) dr_low++;
      if (ql0 || ql1) last_seen = 1'b1;
      prev_qv = qv0;
      check("busy_eq_qv_msb", b0, qv0);
      check("busy_eq_qv_lsb", b1, qv1);
      check("ready_match", dr1, dr0);
      if (!qv0) check("idle_q_msb", q0, 0);
      if (!qv1) check("idle_q_lsb", q1, 0);
      if (qv0 && q_ready) begin
        if (sb0.size() == 0) check("sb0_unexpected_bit", 1, 0);
        else begin
          e = sb0.pop_front();
          check("q_msb", q0, e.d);
          check("q_last_msb", ql0, e.last);
        end
      end
      if (qv1 && q_ready) begin
        if (sb1.size() == 0) check("sb1_unexpected_bit", 1, 0);
        else begin
          e = sb1.pop_front();
          check("q_lsb", q1, e.d);
          check("q_last_lsb", ql1, e.last);
        end
      end
      if (din_valid && dr0) push_frame(cur_idx);
    end
  end

  task automatic send(input int idx, output logic ql_at_accept);
    logic acc;
    int k;
    cur_idx   = idx;
    din       = tbl[idx].w;
    din_valid = 1'b1;
    acc = 1'b0;
    ql_at_accept = 1'b0;
    for (k = 0; k < 60 && !acc; k++) begin
      acc = dr0;
      ql_at_accept = ql0;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", acc, 1);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready);
    for (int k = 0; k < 200; k++) begin
      if (!qv0 && !qv1) break;
      if (rand_ready) q_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    q_ready = 1'b1;
    check("idle_timeout", qv0 | qv1, 0);
  endtask

  task automatic clear_stats();
    valid_cycles = 0;
    rises = 0;
    dr_low = 0;
    last_seen = 1'b0;
  endtask

  initial begin
    logic ql_acc;
    tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
    tbl[1] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
    tbl[2] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0};
    tbl[3] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
    tbl[4] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};
    tbl[5] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0};
    tbl[6] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    tbl[7] = '{8'h12, 8'b00010010, 8'b01001000, 1'b0};
    cur_idx = 0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    q_ready = 1'b1;
    clear_stats();
    prev_qv = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_din_ready", dr0, 0);
    check("rst_q_valid", qv0, 0);
    check("rst_q", q0, 0);
    check("rst_q_last", ql0, 0);
    check("rst_busy", b0, 0);
    rst = 1'b0;
    #1;
    check("post_rst_din_ready", dr0, 1);

    // Basic frame
    clear_stats();
    send(0, ql_acc);
    check("first_bit_latency", qv0, 1);
    check("first_bit_value", q0, 1);
    wait_idle(1'b0);
    check("basic_valid_span", valid_cycles, N);
    check("basic_ready_low", dr_low, N - 1);

    // Back-to-back frames
    clear_stats();
    send(0, ql_acc);
    send(1, ql_acc);
    check("b2b_accept_on_last", ql_acc, 1);
    wait_idle(1'b0);
    check("b2b_valid_span", valid_cycles, 2 * N);
    check("b2b_no_gap", rises, 1);

    // Backpressure on bit indices 2 and 5
    clear_stats();
    send(2, ql_acc);
    repeat (2) begin @(posedge clk); #1; end
    q_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("bp_stall2_q_msb", q0, 1);
      check("bp_stall2_q_lsb", q1, 0);
      check("bp_stall2_qv", qv0, 1);
    end
    q_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    q_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("bp_stall5_q_msb", q0, 0);
      check("bp_stall5_q_lsb", q1, 1);
      check("bp_stall5_ql", ql0, 0);
    end
    q_ready = 1'b1;
    wait_idle(1'b0);
    check("bp_valid_span", valid_cycles, N + 4);

    // LSB-first single bit word
    send(3, ql_acc);
    wait_idle(1'b0);

    // Reset mid-frame after bit 3
    clear_stats();
    send(4, ql_acc);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_q_valid", qv0, 0);
    check("abort_q", q0, 0);
    check("abort_q_last", ql0, 0);
    check("abort_lsb_q_valid", qv1, 0);
    check("abort_no_last", last_seen, 0);
    #1;
    check("abort_din_ready", dr0, 1);
    send(5, ql_acc);
    wait_idle(1'b0);

    // Whole table under random backpressure
    for (int i = 0; i < 8; i++) begin
      send(i, ql_acc);
      wait_idle(1'b1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
